// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared constants and types for the LCD cell-matrix display path.
//   - Panel timing (480x272 panel, totals include blanking)
//   - Cell matrix geometry and the blank border drawn around it
//   - Arbiter FSM state enumeration
// ----------------------------------------------------------------------------
package lcd_pkg;

    // Panel timing, in pixel clocks / lines
    localparam int H_ACTIVE = 480;
    localparam int H_TOTAL  = 525;
    localparam int V_ACTIVE = 272;
    localparam int V_TOTAL  = 288;

    // Cell matrix geometry
    localparam int CELL_COLS = 28;
    localparam int CELL_ROWS = 15;
    localparam int CELL_PX   = 16;   // each cell is 16x16 pixels
    localparam int BORDER    = 16;   // blank margin before the first cell
    localparam int ROW_AW    = 4;    // matrix row address width

    // Store-port occupant for the current cycle
    typedef enum logic [1:0] {
        IDLE,
        DISP,
        GAME,
        CLR
    } arb_state_t;

endpackage

// File: rtl/lcd_cell_ram.sv
// ----------------------------------------------------------------------------
// lcd_cell_ram
// Cell-occupancy store: ROWS words of COLS bits, one shared read/write port.
// Read is combinational from the register array so the arbiter can capture
// the word into its own registers in the same cycle it owns the port.
// Addresses at or beyond ROWS read as zero and ignore writes.
//
// Ports
//   clk    pixel clock
//   rst_n  asynchronous active-low reset, clears every row
//   we     write enable for the addressed row
//   addr   row address
//   wdata  row write data, bit c = column c
//   rdata  row read data for addr
// ----------------------------------------------------------------------------
module lcd_cell_ram
    import lcd_pkg::*;
#(
    parameter int ROWS = 15,
    parameter int COLS = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ROW_AW-1:0] addr,
    input  logic [COLS-1:0]   wdata,
    output logic [COLS-1:0]   rdata
);

    logic [COLS-1:0] mem_reg [ROWS];
    logic            addr_ok;

    assign addr_ok = (addr < ROW_AW'(ROWS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && addr_ok) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign rdata = addr_ok ? mem_reg[addr] : '0;

endmodule

// File: rtl/lcd_cell_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_cell_arbiter
// Owns the single-port cell store and shares it between three users:
//   DISP  - once per line, copies the matrix row for the current scan line
//           into a line buffer that feeds temp_bit for the whole line
//   CLR   - zeroes the matrix one row per cycle after gm_clr
//   GAME  - one read or write per gm_req handshake
// Priority for the port is DISP > CLR > GAME.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt          timing generator counters
//   active_x, active_y    active-area pixel coordinates
//   temp_bit              cell-occupied bit, one cycle after active_x
//   frame_start           one-cycle pulse after (h_cnt, v_cnt) == (0, 0)
//   gm_req/gm_we/gm_row/gm_wdata   game access request (held until gm_ack)
//   gm_ack, gm_rdata      access complete pulse and read data
//   gm_clr, clr_busy      clear request pulse and clear-in-progress flag
// ----------------------------------------------------------------------------
module lcd_cell_arbiter #(
    parameter logic [11:0] FETCH_H   = 12'd4,
    parameter int          CELL_COLS = 28,
    parameter int          CELL_ROWS = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [11:0]          h_cnt,
    input  logic [11:0]          v_cnt,
    input  logic [11:0]          active_x,
    input  logic [11:0]          active_y,
    output logic                 temp_bit,
    output logic                 frame_start,
    input  logic                 gm_req,
    input  logic                 gm_we,
    input  logic [3:0]           gm_row,
    input  logic [CELL_COLS-1:0] gm_wdata,
    output logic                 gm_ack,
    output logic [CELL_COLS-1:0] gm_rdata,
    input  logic                 gm_clr,
    output logic                 clr_busy
);
    import lcd_pkg::*;

    // Visible cell window, inclusive, in active-area coordinates
    localparam logic [11:0]       X_LO     = 12'(BORDER);
    localparam logic [11:0]       X_HI     = 12'(BORDER + CELL_COLS * CELL_PX - 1);
    localparam logic [11:0]       Y_LO     = 12'(BORDER);
    localparam logic [11:0]       Y_HI     = 12'(BORDER + CELL_ROWS * CELL_PX - 1);
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(CELL_ROWS - 1);

    arb_state_t           state_reg;
    logic [ROW_AW-1:0]    clr_row_reg;
    logic                 clr_busy_reg;
    logic [CELL_COLS-1:0] linebuf_reg;
    logic                 row_valid_reg;
    logic                 temp_bit_reg;
    logic                 frame_start_reg;
    logic                 gm_ack_reg;
    logic [CELL_COLS-1:0] gm_rdata_reg;

    logic                 fetch_next;
    logic                 clr_pend;
    logic                 game_ok;
    logic                 gm_row_ok;
    logic                 y_in;
    logic                 x_in;
    logic [ROW_AW-1:0]    disp_row;
    logic [4:0]           col_idx;

    logic                 ram_we;
    logic [ROW_AW-1:0]    ram_addr;
    logic [CELL_COLS-1:0] ram_wdata;
    logic [CELL_COLS-1:0] ram_rdata;

    // The state register names the port occupant of the current cycle, so
    // the fetch decision is taken one pixel early: the timing generator
    // counts h_cnt up by one per clock, and this lands DISP exactly on the
    // cycle with h_cnt == FETCH_H.
    assign fetch_next = (h_cnt == FETCH_H - 12'd1);

    // A clear requested this cycle already outranks a game access.
    assign clr_pend  = clr_busy_reg | gm_clr;

    // gm_req is still high during the ack cycle; ignore it there so one
    // request is never served twice.
    assign game_ok   = gm_req & ~gm_ack_reg;
    assign gm_row_ok = (gm_row < ROW_AW'(CELL_ROWS));

    // Row and column indices: drop the 16 px border cell, divide by 16.
    assign y_in     = (active_y >= Y_LO) && (active_y <= Y_HI);
    assign disp_row = active_y[ROW_AW+3:4] - ROW_AW'(1);
    assign x_in     = (active_x >= X_LO) && (active_x <= X_HI);
    assign col_idx  = active_x[8:4] - 5'd1;

    // Store port mux
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_row;
        ram_wdata = '0;
        case (state_reg)
            DISP: begin
                ram_addr = disp_row;
            end
            GAME: begin
                ram_addr  = gm_row;
                ram_we    = gm_we & gm_row_ok;
                ram_wdata = gm_wdata;
            end
            CLR: begin
                ram_addr = clr_row_reg;
                ram_we   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    lcd_cell_ram #(
        .ROWS (CELL_ROWS),
        .COLS (CELL_COLS)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            clr_row_reg     <= '0;
            clr_busy_reg    <= 1'b0;
            linebuf_reg     <= '0;
            row_valid_reg   <= 1'b0;
            temp_bit_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            gm_ack_reg      <= 1'b0;
            gm_rdata_reg    <= '0;
        end else begin
            gm_ack_reg      <= 1'b0;
            frame_start_reg <= (h_cnt == 12'd0) && (v_cnt == 12'd0);

            // Line buffer is only reloaded by DISP, so game writes to the
            // displayed row cannot tear the current line.
            temp_bit_reg    <= row_valid_reg & x_in & linebuf_reg[col_idx];

            // A new clear request (also while busy) restarts from row 0.
            if (gm_clr) begin
                clr_busy_reg <= 1'b1;
                clr_row_reg  <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (fetch_next)    state_reg <= DISP;
                    else if (clr_pend) state_reg <= CLR;
                    else if (game_ok)  state_reg <= GAME;
                end

                DISP: begin
                    row_valid_reg <= y_in;
                    if (y_in) begin
                        linebuf_reg <= ram_rdata;
                    end
                    if (clr_pend)     state_reg <= CLR;
                    else if (game_ok) state_reg <= GAME;
                    else              state_reg <= IDLE;
                end

                GAME: begin
                    gm_ack_reg <= 1'b1;
                    if (!gm_we) begin
                        gm_rdata_reg <= gm_row_ok ? ram_rdata : '0;
                    end
                    if (fetch_next)    state_reg <= DISP;
                    else if (clr_pend) state_reg <= CLR;
                    else               state_reg <= IDLE;
                end

                CLR: begin
                    if (gm_clr) begin
                        state_reg <= fetch_next ? DISP : CLR;
                    end else if (clr_row_reg == LAST_ROW) begin
                        clr_busy_reg <= 1'b0;
                        state_reg    <= fetch_next ? DISP : IDLE;
                    end else begin
                        // Row index advances before a fetch pause so the
                        // clear resumes on the next unwritten row.
                        clr_row_reg <= clr_row_reg + ROW_AW'(1);
                        state_reg   <= fetch_next ? DISP : CLR;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign temp_bit    = temp_bit_reg;
    assign frame_start = frame_start_reg;
    assign gm_ack      = gm_ack_reg;
    assign gm_rdata    = gm_rdata_reg;
    assign clr_busy    = clr_busy_reg;

endmodule

// File: tb/tb_lcd_cell_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_cell_arbiter
// Directed bench for lcd_cell_arbiter with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_lcd_cell_arbiter;
    import lcd_pkg::*;

    localparam logic [11:0] FETCH = 12'd4;
    localparam logic [11:0] H_IDLE = 12'd100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] h_cnt, v_cnt, active_x, active_y;
    logic        temp_bit, frame_start;
    logic        gm_req, gm_we, gm_ack, gm_clr, clr_busy;
    logic [3:0]  gm_row;
    logic [27:0] gm_wdata, gm_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lcd_cell_arbiter #(
        .FETCH_H   (FETCH),
        .CELL_COLS (28),
        .CELL_ROWS (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active_x    (active_x),
        .active_y    (active_y),
        .temp_bit    (temp_bit),
        .frame_start (frame_start),
        .gm_req      (gm_req),
        .gm_we       (gm_we),
        .gm_row      (gm_row),
        .gm_wdata    (gm_wdata),
        .gm_ack      (gm_ack),
        .gm_rdata    (gm_rdata),
        .gm_clr      (gm_clr),
        .clr_busy    (clr_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One game handshake; waits a bounded number of cycles for gm_ack.
    task automatic game_access(input logic we, input logic [3:0] row,
                               input logic [27:0] wd, output logic [27:0] rd);
        bit got;
        got      = 1'b0;
        gm_req   = 1'b1;
        gm_we    = we;
        gm_row   = row;
        gm_wdata = wd;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (gm_ack) got = 1'b1;
        end
        rd     = gm_rdata;
        gm_req = 1'b0;
        check_val("gm_ack_seen", got, 1);
        $display("gm %s row %0d wdata %07h rdata %07h", we ? "wr" : "rd", row, wd, rd);
    endtask

    // Drive one fetch slot with the given scan line.
    task automatic fetch(input logic [11:0] y);
        active_y = y;
        h_cnt    = FETCH - 12'd1;
        tick();
        h_cnt    = FETCH;
        tick();
        h_cnt    = H_IDLE;
    endtask

    // Sweep active_x across the line; temp_bit must be 1 only for x in the
    // two given inclusive ranges.
    task automatic sweep_check(input string tag, input int lo1, input int hi1,
                               input int lo2, input int hi2);
        for (int x = 0; x < 480; x++) begin
            logic e;
            active_x = 12'(x);
            tick();
            e = ((x >= lo1 && x <= hi1) || (x >= lo2 && x <= hi2));
            check_val(tag, temp_bit, e);
        end
        $display("sweep %s done", tag);
    endtask

    initial begin
        logic [27:0] rd;
        logic [27:0] exp_row;
        int          fs_cnt;
        int          busy_cnt;
        int          last_busy;
        int          ack_idx;
        bit          acked;
        logic [27:0] clr_rd;

        rst_n    = 1'b0;
        h_cnt    = H_IDLE;
        v_cnt    = 12'd100;
        active_x = '0;
        active_y = '0;
        gm_req   = 1'b0;
        gm_we    = 1'b0;
        gm_row   = '0;
        gm_wdata = '0;
        gm_clr   = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_temp_bit", temp_bit, 0);
        check_val("rst_frame_start", frame_start, 0);
        check_val("rst_gm_ack", gm_ack, 0);
        check_val("rst_gm_rdata", gm_rdata, 0);
        check_val("rst_clr_busy", clr_busy, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Row 3 = 5 -> columns 0 and 2 lit on line 64
        game_access(1'b1, 4'd3, 28'h0000005, rd);
        fetch(12'd64);
        sweep_check("pix_row3", 16, 31, 48, 63);

        // Read coinciding with the fetch slot: DISP first, ack two cycles on
        h_cnt = FETCH - 12'd1;
        tick();
        h_cnt    = FETCH;
        active_y = 12'd32;          // row 1, still empty
        gm_req   = 1'b1;
        gm_we    = 1'b0;
        gm_row   = 4'd3;
        tick();
        h_cnt = H_IDLE;
        check_val("fetch_rd_ack_early", gm_ack, 0);
        tick();
        check_val("fetch_rd_ack", gm_ack, 1);
        check_val("fetch_rd_data", gm_rdata, 28'h0000005);
        $display("gm rd row 3 at fetch slot rdata %07h", gm_rdata);
        gm_req   = 1'b0;
        active_x = 12'd20;
        tick();
        check_val("disp_first_reload", temp_bit, 0);

        // Out-of-range row and store contents
        game_access(1'b1, 4'd0, 28'h0000001, rd);
        game_access(1'b1, 4'd14, 28'h8000001, rd);
        game_access(1'b1, 4'd15, 28'hFFFFFFF, rd);
        game_access(1'b0, 4'd15, 28'h0, rd);
        check_val("row15_read", rd, 0);
        for (int r = 0; r < 15; r++) begin
            exp_row = (r == 0) ? 28'h0000001 : (r == 3) ? 28'h0000005 :
                      (r == 14) ? 28'h8000001 : 28'h0;
            game_access(1'b0, 4'(r), 28'h0, rd);
            check_val($sformatf("row%0d_after_row15", r), rd, exp_row);
        end

        // Window boundaries on row 14 (columns 0 and 27)
        fetch(12'd255);
        active_x = 12'd15;  tick(); check_val("x15", temp_bit, 0);
        active_x = 12'd16;  tick(); check_val("x16", temp_bit, 1);
        active_x = 12'd447; tick(); check_val("x447", temp_bit, 0);
        active_x = 12'd448; tick(); check_val("x448", temp_bit, 1);
        active_x = 12'd463; tick(); check_val("x463", temp_bit, 1);
        active_x = 12'd464; tick(); check_val("x464", temp_bit, 0);
        fetch(12'd256);
        active_x = 12'd16;  tick(); check_val("y256", temp_bit, 0);
        fetch(12'd15);
        active_x = 12'd16;  tick(); check_val("y15", temp_bit, 0);
        fetch(12'd16);
        active_x = 12'd16;  tick(); check_val("y16_x16", temp_bit, 1);
        active_x = 12'd32;  tick(); check_val("y16_x32", temp_bit, 0);

        // Tear-free: a write to the buffered row waits for the next fetch
        fetch(12'd64);
        active_x = 12'd20;
        tick();
        check_val("tear_pre", temp_bit, 1);
        game_access(1'b1, 4'd3, 28'h0000002, rd);
        sweep_check("tear_old", 16, 31, 48, 63);
        fetch(12'd64);
        sweep_check("tear_new", 32, 47, -1, -1);

        // frame_start over two frames of a shortened line
        fs_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < V_TOTAL; v++) begin
                for (int h = 0; h < 8; h++) begin
                    h_cnt = 12'(h);
                    v_cnt = 12'(v);
                    tick();
                    if (frame_start) fs_cnt++;
                    if (f == 0 && v == 0 && h == 0) check_val("fs_first", frame_start, 1);
                    if (f == 0 && v == 0 && h == 1) check_val("fs_width", frame_start, 0);
                end
            end
        end
        h_cnt = H_IDLE;
        v_cnt = 12'd100;
        tick();
        if (frame_start) fs_cnt++;
        check_val("fs_count", fs_cnt, 2);

        // Clear with a fetch slot mid-clear and a pending read of row 14
        busy_cnt  = 0;
        last_busy = -1;
        ack_idx   = -1;
        acked     = 1'b0;
        clr_rd    = 28'hBAD;
        active_y  = 12'd0;
        for (int k = 0; k < 40; k++) begin
            gm_clr = (k == 0);
            gm_req = (k >= 1) && !acked;
            gm_we  = 1'b0;
            gm_row = 4'd14;
            h_cnt  = (k == 5) ? FETCH - 12'd1 : (k == 6) ? FETCH : H_IDLE;
            tick();
            if (clr_busy) begin
                busy_cnt++;
                last_busy = k;
            end
            if (gm_ack && !acked) begin
                acked   = 1'b1;
                ack_idx = k;
                clr_rd  = gm_rdata;
            end
        end
        gm_req = 1'b0;
        h_cnt  = H_IDLE;
        $display("clear: busy %0d cycles, last busy %0d, ack at %0d", busy_cnt, last_busy, ack_idx);
        check_val("clr_busy_cycles", busy_cnt, 16);
        check_val("clr_busy_last", last_busy, 15);
        check_val("clr_pending_acked", acked, 1);
        check_val("clr_pending_ack_idx", ack_idx, 18);
        check_val("clr_pending_rdata", clr_rd, 0);
        for (int r = 0; r < 15; r++) begin
            game_access(1'b0, 4'(r), 28'h0, rd);
            check_val($sformatf("row%0d_cleared", r), rd, 0);
        end

        // Reset in the middle of a clear
        game_access(1'b1, 4'd14, 28'h8000001, rd);
        fetch(12'd240);
        active_x = 12'd16;
        tick();
        check_val("pre_rst_temp", temp_bit, 1);
        game_access(1'b0, 4'd14, 28'h0, rd);
        check_val("pre_rst_rdata", rd, 28'h8000001);
        gm_clr = 1'b1;
        tick();
        gm_clr = 1'b0;
        tick();
        check_val("pre_rst_busy", clr_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_temp", temp_bit, 0);
        check_val("async_rst_busy", clr_busy, 0);
        check_val("async_rst_rdata", gm_rdata, 0);
        check_val("async_rst_ack", gm_ack, 0);
        check_val("async_rst_fs", frame_start, 0);
        tick();
        rst_n = 1'b1;
        tick();
        gm_req = 1'b1;
        gm_we  = 1'b0;
        gm_row = 4'd14;
        tick();
        check_val("post_rst_ack_early", gm_ack, 0);
        tick();
        check_val("post_rst_ack", gm_ack, 1);
        check_val("post_rst_row14", gm_rdata, 0);
        $display("gm rd row 14 after reset rdata %07h", gm_rdata);
        gm_req = 1'b0;
        check_val("post_rst_busy", clr_busy, 0);
        for (int r = 0; r < 15; r++) begin
            game_access(1'b0, 4'(r), 28'h0, rd);
            check_val($sformatf("row%0d_post_rst", r), rd, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_cell_arbiter.md
LCD_CELL_ARBITER -- requirements
Module: lcd_cell_arbiter

Interface
REQ-001 SHALL have parameter FETCH_H, default 12'd4, meaning the h_cnt value of the display-fetch slot, which lies inside horizontal blanking.
REQ-002 SHALL have parameter CELL_COLS, default 28, meaning matrix columns, each 16 px wide.
REQ-003 SHALL have parameter CELL_ROWS, default 15, meaning matrix rows, each 16 px high.
REQ-004 clk  in  1  pixel clock; the block has one clock.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 h_cnt  in  12  horizontal counter from the timing generator.
REQ-007 v_cnt  in  12  vertical counter from the timing generator.
REQ-008 active_x  in  12  active-area x coordinate.
REQ-009 active_y  in  12  active-area y coordinate.
REQ-010 temp_bit  out  1  cell-occupied bit for the current pixel.
REQ-011 frame_start  out  1  one-cycle pulse marking the start of a frame.
REQ-012 gm_req  in  1  game-port access request; held high until acknowledged.
REQ-013 gm_we  in  1  1 = write, 0 = read.
REQ-014 gm_row  in  4  target matrix row.
REQ-015 gm_wdata  in  28  row write data; bit c = column c.
REQ-016 gm_ack  out  1  one-cycle access-complete pulse.
REQ-017 gm_rdata  out  28  read data, valid while gm_ack is high, held otherwise.
REQ-018 gm_clr  in  1  pulse requesting a clear of the whole matrix.
REQ-019 clr_busy  out  1  high while a clear is in progress.

Function
REQ-020 SHALL store the matrix as CELL_ROWS words of CELL_COLS bits in a single-port store: one access per cycle.
REQ-021 SHALL have FSM states IDLE, DISP, GAME, CLR.
- Exactly one state occupies the store per cycle.
REQ-022 Fetch slot: the cycle when h_cnt == FETCH_H.
- Priority: DISP over CLR over GAME.
REQ-023 DISP, one cycle:
- If 16 <= active_y <= 255: load row (active_y>>4)-1 into a 28-bit line buffer and set row_valid.
- Otherwise clear row_valid.
- Then return to the interrupted state (CLR) or to IDLE.
REQ-024 GAME, one cycle, entered from IDLE when gm_req is high:
- Write: stores gm_wdata.
- Read: captures gm_rdata.
- gm_ack pulses on the cycle after the access.
- Re-arbitration happens one cycle after ack.
REQ-025 gm_row >= CELL_ROWS:
- Write is discarded.
- Read returns 28'd0.
- gm_ack is still given.
REQ-026 gm_req coinciding with the fetch slot is served no earlier than the cycle after DISP.
- gm_req dropped before ack is a protocol violation: no requirement.
REQ-027 gm_clr:
- Sets clr_busy the next cycle.
- CLR writes zeros to rows 0..CELL_ROWS-1, one row per cycle.
- A fetch slot pauses CLR for one cycle without losing the row index.
- clr_busy drops the cycle after row 14 is written.
- gm_clr while busy restarts at row 0.
- GAME requests wait until the clear is done.
REQ-028 temp_bit is registered, one cycle after active_x.
- temp_bit = row_valid AND 16 <= active_x <= 463 AND linebuf[(active_x>>4)-1].
- temp_bit = 0 otherwise.
REQ-029 A write to the row currently in the line buffer SHALL NOT alter temp_bit until the next fetch slot, so lines are tear-free.
REQ-030 frame_start is registered high for one cycle after h_cnt == 0 and v_cnt == 0.
REQ-031 Coordinate arithmetic is 12-bit unsigned; the column index is a 5-bit result.

Reset
REQ-032 rst_n low SHALL asynchronously clear:
- all store rows, line buffer and row_valid;
- FSM to IDLE and the clear row index to 0;
- outputs: temp_bit 0, frame_start 0, gm_ack 0, gm_rdata 0, clr_busy 0.
REQ-033 Reset during CLR or GAME aborts the operation; no ack is issued.

Structure
REQ-034 Shared package lcd_pkg SHALL hold:
- H/V timing constants;
- CELL_COLS, CELL_ROWS;
- matrix border offset 16;
- the FSM state enumeration.
REQ-035 The store SHALL be a sub-module lcd_cell_ram: 15x28 register array, one read/write port, asynchronous clear.

Verification
REQ-036 Write row 3 = 28'h0000005; set active_y=64 through a fetch slot; sweep active_x.
- temp_bit = 1 one cycle after active_x 16..31 and 48..63.
- temp_bit = 0 elsewhere.
REQ-037 Assert gm_req, gm_we=0, row 3 on the fetch-slot cycle.
- DISP occurs first.
- gm_ack appears 2 cycles later with gm_rdata = 28'h0000005.
REQ-038 Pulse gm_clr with a fetch slot mid-clear.
- clr_busy is high for 16 cycles.
- All rows read back 0.
- A pending gm_req is acked only after clr_busy falls.
REQ-039 Write gm_row=15 with data 28'hFFFFFFF, then read gm_row=15.
- Both accesses are acked.
- The read returns 0.
- Rows 0..14 are unchanged.
REQ-040 Write the line-buffered row mid-line.
- temp_bit keeps the old pattern until the next fetch slot.
- frame_start pulses exactly once per V_TOTAL lines.
REQ-041 Deassert rst_n during CLR.
- All outputs are 0 immediately.
- After release, the store reads 0 and the FSM is IDLE.
